// File: rtl/pre_if_multi_outstanding_pkg.sv
// Shared definitions for the multi-outstanding pre-IF fetch stage:
// CP0 exception code, default reset vector, FSM states and the output entry layout.
package pre_if_multi_outstanding_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc00000;
    localparam logic [4:0]  EXC_ADEL         = 5'h04;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_ERR_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_e;

    // One entry handed to IF: PC, instruction word and exception info (70 bits).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [4:0]  exccode;
    } out_entry_t;

    localparam int OUT_ENTRY_W = $bits(out_entry_t);

endpackage

// File: rtl/pre_if_multi_outstanding_fetch_fifo.sv
// Synchronous FIFO with flush; push and pop may occur in the same cycle.
// A push while full is only legal when a pop happens in the same cycle.
module pre_if_multi_outstanding_fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] slots_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = slots_q[rd_ptr_q];

    // Pointer and occupancy update; flush empties the FIFO and overrides push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Pointer/counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush) slots_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/pre_if_multi_outstanding.sv
// Pre-IF fetch stage keeping up to DEPTH requests in flight on the sram-like port.
// Returned words are paired with their PC and delivered in order to IF.
// Redirects drop stale returns through a discard counter.
// Optional macro PRE_IF_KSEG_MAP_EN enables the fixed kseg0/kseg1 address mapping.
//
// Handshakes: out_valid/out_ready transfer an entry on any cycle where both are high;
// out_valid never depends on out_ready. inst_sram_req may drop without addr_ok.
module pre_if_multi_outstanding
    import pre_if_multi_outstanding_pkg::*;
#(
    parameter  int          DEPTH    = 4,
    parameter  logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    localparam int          CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_addr,
    output logic        inst_sram_cached,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_exception,
    output logic [4:0]  out_exccode
);

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   discard_cnt_q, discard_cnt_d;

    logic               accept;
    logic [CNT_W-1:0]   occ;

    logic [31:0]        pf_pop_data;
    logic               pf_empty, pf_full;
    logic [CNT_W-1:0]   pf_count;

    logic               ob_push, ob_pop, ob_empty, ob_full;
    out_entry_t         ob_push_data, ob_head;
    logic [OUT_ENTRY_W-1:0] ob_pop_data;
    logic [CNT_W-1:0]   ob_count;

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'b1111;
    assign inst_sram_wdata = 32'd0;

    // Everything still in flight plus everything buffered must fit in DEPTH.
    assign occ           = inflight_q + ob_count;
    assign inst_sram_req = !reset && (state_q == S_RUN) && (fetch_pc_q[1:0] == 2'b00)
                           && (occ < CNT_W'(DEPTH)) && !redirect;
    assign accept        = inst_sram_req && inst_sram_addr_ok;

`ifdef PRE_IF_KSEG_MAP_EN
    // kseg0/kseg1 strip the top three bits; only kseg0 is cacheable.
    always_comb begin
        inst_sram_addr   = fetch_pc_q;
        inst_sram_cached = 1'b1;
        if (fetch_pc_q[31:30] == 2'b10) begin
            inst_sram_addr   = {3'b000, fetch_pc_q[28:0]};
            inst_sram_cached = (fetch_pc_q[31:29] == 3'b100);
        end
    end
`else
    assign inst_sram_addr   = fetch_pc_q;
    assign inst_sram_cached = 1'b0;
`endif

    assign ob_head       = ob_pop_data;
    assign out_valid     = !reset && !ob_empty && !redirect;
    assign ob_pop        = out_valid && out_ready;
    assign out_pc        = ob_head.pc;
    assign out_inst      = ob_head.inst;
    assign out_exception = ob_head.exc;
    assign out_exccode   = ob_head.exccode;

    // Next-state: redirect wins; otherwise advance PC, route returns, run the error FSM.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q + CNT_W'(accept) - CNT_W'(inst_sram_data_ok);
        discard_cnt_d = discard_cnt_q;
        ob_push       = 1'b0;
        ob_push_data  = '0;
        if (redirect) begin
            fetch_pc_d    = redirect_pc;
            state_d       = S_RUN;
            // Every word still outstanding after this cycle belongs to the old stream.
            discard_cnt_d = inflight_q - CNT_W'(inst_sram_data_ok);
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
            if (inst_sram_data_ok) begin
                if (discard_cnt_q != '0) begin
                    discard_cnt_d = discard_cnt_q - CNT_W'(1);
                end else begin
                    ob_push              = 1'b1;
                    ob_push_data.pc      = pf_pop_data;
                    ob_push_data.inst    = inst_sram_rdata;
                    ob_push_data.exc     = 1'b0;
                    ob_push_data.exccode = 5'h00;
                end
            end
            case (state_q)
                S_RUN: begin
                    if (fetch_pc_q[1:0] != 2'b00) state_d = S_ERR_WAIT;
                end
                S_ERR_WAIT: begin
                    // Error entry goes out only after older returns have drained.
                    if ((inflight_q == '0) && !ob_full) begin
                        ob_push              = 1'b1;
                        ob_push_data.pc      = fetch_pc_q;
                        ob_push_data.inst    = 32'd0;
                        ob_push_data.exc     = 1'b1;
                        ob_push_data.exccode = EXC_ADEL;
                        state_d              = S_HALT;
                    end
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_RUN;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RUN;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= '0;
            discard_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

`ifndef SYNTHESIS
    // A return with nothing outstanding means the bridge broke protocol.
    always_ff @(posedge clk) begin
        if (!reset && inst_sram_data_ok) begin
            assert (inflight_q != '0)
            else $error("pre_if: data_ok with no request in flight");
        end
    end
`endif

    // PCs of accepted requests, popped as their words come back.
    pre_if_multi_outstanding_fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pending_pc (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (accept),
        .push_data (fetch_pc_q),
        .pop       (inst_sram_data_ok),
        .pop_data  (pf_pop_data),
        .empty     (pf_empty),
        .full      (pf_full),
        .count     (pf_count)
    );

    logic unused_pf;
    assign unused_pf = &{1'b0, pf_empty, pf_full, pf_count};

    // Entries ready for IF; flushed on redirect.
    pre_if_multi_outstanding_fetch_fifo #(
        .WIDTH (OUT_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (ob_push),
        .push_data (ob_push_data),
        .pop       (ob_pop),
        .pop_data  (ob_pop_data),
        .empty     (ob_empty),
        .full      (ob_full),
        .count     (ob_count)
    );

endmodule

// File: tb/tb_pre_if_multi_outstanding.sv
// Bench for pre_if_multi_outstanding: directed scenarios followed by random traffic,
// checked against a transaction-level model (memory queue + expected output queue).
module tb_pre_if_multi_outstanding;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_cached;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_exception;
    logic [4:0]  out_exccode;

    pre_if_multi_outstanding #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_cached  (inst_sram_cached),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_inst          (out_inst),
        .out_exception     (out_exception),
        .out_exccode       (out_exccode)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    typedef struct {
        logic [31:0] pc;
        int          due;
        logic        stale;
    } mem_t;

    mem_t        mem_q[$];
    logic [64:0] exp_q[$];   // {exc, pc, inst}
    logic [31:0] model_pc;
    int          cyc;
    int          checks;
    int          errors;
    logic        chk_out;

    // Observations
    int          n_acc;
    int          n_deliv;
    logic        s_out_valid;
    logic [31:0] s_out_pc;
    logic [31:0] s_out_inst;
    logic        s_out_exc;
    logic [4:0]  s_out_exccode;
    logic        track_first;
    logic [31:0] first_pc;
    logic [31:0] last_acc_pc;
    logic        wrap_seen;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [31:0] map_addr(input logic [31:0] pc);
`ifdef PRE_IF_KSEG_MAP_EN
        if (pc >= 32'h8000_0000 && pc < 32'hc000_0000) return pc - (pc & 32'he000_0000);
        return pc;
`else
        return pc;
`endif
    endfunction

    function automatic logic map_cached(input logic [31:0] pc);
`ifdef PRE_IF_KSEG_MAP_EN
        return !(pc >= 32'ha000_0000 && pc < 32'hc000_0000);
`else
        return 1'b0 & pc[0];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata = 32'd0;
        out_ready = 1'b0;
        #1;
        chk("reset_req", {31'd0, inst_sram_req}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_q.delete();
        exp_q.delete();
        model_pc = 32'hbfc0_0000;
        n_acc = 0;
        n_deliv = 0;
        last_acc_pc = 32'd0;
    endtask

    // One clock cycle: drive inputs at negedge, check, then advance the model.
    task automatic step(input logic a_ok, input logic redir, input logic [31:0] rpc,
                        input logic o_rdy, input int lat);
        logic req_exp;
        logic [64:0] e;
        mem_t m;
        @(negedge clk);
        inst_sram_addr_ok = a_ok;
        redirect = redir;
        redirect_pc = rpc;
        out_ready = o_rdy;
        inst_sram_data_ok = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        inst_sram_rdata = inst_sram_data_ok ? word_of(mem_q[0].pc) : $urandom;
        #1;
        s_out_valid = out_valid;
        s_out_pc = out_pc;
        s_out_inst = out_inst;
        s_out_exc = out_exception;
        s_out_exccode = out_exccode;

        req_exp = !redir && (model_pc[1:0] == 2'b00) && ((mem_q.size() + exp_q.size()) < DEPTH);
        chk("req", {31'd0, inst_sram_req}, {31'd0, req_exp});
        if (chk_out)
            chk("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0) && !redir});

        if (out_valid && out_ready) begin
            n_deliv++;
            if (track_first) begin
                first_pc = out_pc;
                track_first = 1'b0;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (chk_out) begin
                    chk("out_pc", out_pc, e[63:32]);
                    chk("out_inst", out_inst, e[31:0]);
                    chk("out_exception", {31'd0, out_exception}, {31'd0, e[64]});
                end
            end
        end

        if (inst_sram_data_ok) begin
            m = mem_q.pop_front();
            if (!m.stale && !redir) exp_q.push_back({1'b0, m.pc, word_of(m.pc)});
        end

        if (inst_sram_req && inst_sram_addr_ok) begin
            if (last_acc_pc == 32'hffff_fffc && model_pc == 32'h0) wrap_seen = 1'b1;
            chk("addr", inst_sram_addr, map_addr(model_pc));
            chk("cached", {31'd0, inst_sram_cached}, {31'd0, map_cached(model_pc)});
            mem_q.push_back('{pc: model_pc, due: cyc + lat, stale: 1'b0});
            last_acc_pc = model_pc;
            model_pc = model_pc + 32'd4;
            n_acc++;
        end

        if (redir) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            model_pc = rpc;
        end
        cyc++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        chk_out = 1'b1;
        track_first = 1'b0;
        first_pc = 32'd0;
        wrap_seen = 1'b0;
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata = 32'd0;
        out_ready = 1'b0;
        model_pc = 32'hbfc0_0000;

        // Reset state and constant port values
        do_reset();
        #1;
        chk("const_wr", {31'd0, inst_sram_wr}, 32'd0);
        chk("const_size", {30'd0, inst_sram_size}, 32'd2);
        chk("const_wstrb", {28'd0, inst_sram_wstrb}, 32'hf);
        chk("const_wdata", inst_sram_wdata, 32'd0);
`ifdef PRE_IF_KSEG_MAP_EN
        chk("kseg1_addr", inst_sram_addr, 32'h1fc0_0000);
        chk("kseg1_cached", {31'd0, inst_sram_cached}, 32'd0);
`else
        chk("plain_addr", inst_sram_addr, 32'hbfc0_0000);
        chk("plain_cached", {31'd0, inst_sram_cached}, 32'd0);
`endif

        // IF stalled: exactly DEPTH requests, head holds reset PC
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 3);
        chk("stall_acc_count", n_acc, DEPTH);
        chk("stall_out_valid", {31'd0, s_out_valid}, 32'd1);
        chk("stall_out_pc", s_out_pc, 32'hbfc0_0000);

        // Full-throughput streaming in order
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 32'd0, 1'b1, 3);
        chk("stream_deliv_count", {31'd0, n_deliv >= 20}, 32'd1);

        // Redirect coinciding with a data_ok while three are in flight
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b1, 6);
        for (int i = 0; i < 10; i++) begin
            if (mem_q.size() == 3 && mem_q[0].due <= cyc) begin
                step(1'b0, 1'b1, 32'h8000_1000, 1'b1, 3);
                track_first = 1'b1;
                break;
            end
            step(1'b0, 1'b0, 32'd0, 1'b1, 3);
        end
        chk("redir_armed", {31'd0, track_first}, 32'd1);
        n_deliv = 0;
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 32'd0, 1'b1, 3);
        chk("redir_first_pc", first_pc, 32'h8000_1000);
`ifdef PRE_IF_KSEG_MAP_EN
        do_reset();
        step(1'b1, 1'b1, 32'h8000_0000, 1'b1, 2);
        #1;
        chk("kseg0_addr", inst_sram_addr, 32'h0000_0000);
        chk("kseg0_cached", {31'd0, inst_sram_cached}, 32'd1);
`endif

        // Misaligned redirect with two in flight: one AdEL entry, then halt
        do_reset();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'd0, 1'b1, 8);
        chk_out = 1'b0;
        step(1'b1, 1'b1, 32'h8000_0002, 1'b0, 3);
        for (int i = 0; i < 40 && !s_out_valid; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 3);
        chk("err_seen", {31'd0, s_out_valid}, 32'd1);
        chk("err_exc", {31'd0, s_out_exc}, 32'd1);
        chk("err_exccode", {27'd0, s_out_exccode}, 32'h4);
        chk("err_pc", s_out_pc, 32'h8000_0002);
        chk("err_inst", s_out_inst, 32'd0);
        chk("err_stream_empty", mem_q.size(), 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1, 3);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'd0, 1'b1, 3);
        chk("err_once", {31'd0, s_out_valid}, 32'd0);

        // PC wrap past 0xfffffffc
        chk_out = 1'b1;
        step(1'b1, 1'b1, 32'hffff_fff8, 1'b1, 2);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'd0, 1'b1, 2);
        chk("pc_wrap", {31'd0, wrap_seen}, 32'd1);

        // Random traffic with redirects, back-pressure and a mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0,
                 $urandom & 32'hffff_fffc,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(1, 5));
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1);
        chk("drain_mem", mem_q.size(), 32'd0);
        chk("drain_exp", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pre_if_multi_outstanding.md
Name: pre_if_multi_outstanding

Overview:
Next-generation pre-IF fetch stage that keeps up to DEPTH instruction requests in flight on the sram-like instruction port. Pairs each returned word with its PC and delivers the pair in order to IF over a valid/ready interface. A redirect (branch or exception target) drops all stale returns using a discard counter instead of a single discard flag. Sits between the PC-redirect logic and IF; the sram-like bridge is unchanged.

Parameters:
DEPTH, 4, maximum in-flight plus buffered entries; power of 2, at least 2.
RESET_PC, 32'hbfc00000, first fetch address after reset.
CNT_W, $clog2(DEPTH)+1, width of the occupancy and discard counters (derived; not overridden).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
redirect  in  1  flush all fetches and restart at redirect_pc
redirect_pc  in  32  new fetch PC
inst_sram_req  out  1  request valid
inst_sram_wr  out  1  constant 0
inst_sram_size  out  2  constant 2'd2
inst_sram_wstrb  out  4  constant 4'b1111
inst_sram_wdata  out  32  constant 0
inst_sram_addr  out  32  physical fetch address
inst_sram_cached  out  1  cacheable attribute
inst_sram_addr_ok  in  1  request accepted
inst_sram_data_ok  in  1  oldest in-flight word returns
inst_sram_rdata  in  32  returned word
out_valid  out  1  entry available to IF
out_ready  in  1  IF accepts entry
out_pc  out  32  PC of entry
out_inst  out  32  instruction word (0 when out_exception)
out_exception  out  1  entry carries a fetch exception
out_exccode  out  5  exception code (AdEL = 5'h04)

Behaviour:
- Reset: fetch_pc=RESET_PC; inflight=0; discard_cnt=0; both FIFOs empty; state=S_RUN. inst_sram_req=0 and out_valid=0 in the reset cycle.
- Occupancy:
  - occ = inflight + output-buffer count; never exceeds DEPTH.
  - inflight += (req & addr_ok), -= data_ok.
- Request issue: inst_sram_req = state==S_RUN & fetch_pc[1:0]==0 & occ<DEPTH & !redirect.
  - req may drop without addr_ok (redirect or error); this is legal for the bridge.
- On req & addr_ok:
  - push fetch_pc into the pending-PC FIFO; fetch_pc += 4 (mod 2^32, wrap allowed).
  - Next request can issue the following cycle (1 request/cycle throughput).
- On data_ok: pop the pending-PC FIFO.
  - If discard_cnt != 0: decrement it and drop the word.
  - Else: push {pc, rdata, exc=0} into the output buffer.
  - data_ok with inflight==0 is a protocol violation; assertion only.
- Output: out_* = output-buffer head; out_valid = !empty & !redirect. Pop on out_valid & out_ready. Same-cycle push and pop are allowed when full-minus-one.
- Redirect (priority over all else):
  - fetch_pc<=redirect_pc; output buffer flushed; state<=S_RUN.
  - discard_cnt<=inflight - data_ok, i.e. every word still outstanding after this cycle is discarded.
  - If discard_cnt was nonzero and data_ok is high the same cycle, the new value still equals the remaining in-flight count.
- Address error, state machine:
  - S_RUN: fetch_pc[1:0]!=0 and no redirect -> S_ERR_WAIT.
  - S_ERR_WAIT: no requests. When inflight==0 and output buffer not full, push {fetch_pc, 0, exc=1, AdEL} -> S_HALT.
  - S_HALT: no requests until redirect.
- Redirect to a misaligned PC: next cycle enters S_ERR_WAIT; the error entry is pushed once stale returns drain.
- Reset mid-operation: all state cleared. Returns still pending in the bridge are the bridge's responsibility; the bridge is reset together with this block.

Optional Feature:
PRE_IF_KSEG_MAP_EN:
- Defined: fixed kseg mapping.
  - kseg0/kseg1 (pc[31:30]==2'b10): inst_sram_addr = {3'b000, pc[28:0]}.
  - inst_sram_cached = pc[31:29]==3'b100.
  - Other segments: identity address, cached=1.
- Undefined: inst_sram_addr = fetch_pc, inst_sram_cached=0.

Decomposition:
- Shared package cp0 definitions: EXC_AdEL, default RESET_PC.
- One natural sub-module, fetch_fifo: parametrised width/depth synchronous FIFO with flush, push/pop same cycle. Instantiated twice: pending-PC FIFO (width 32) and output buffer (width 70).

Test Plan:
1. Reset, addr_ok=1 every cycle, data_ok 3 cycles later, out_ready=1 -> out_pc 0xbfc00000, 0xbfc00004, ... in order; 4 requests outstanding max.
2. out_ready=0, memory always ready -> exactly 4 requests issued, then req stays 0; out_valid=1 holding pc 0xbfc00000.
3. 3 in flight, redirect to 0x80001000 in the same cycle as a data_ok -> discard_cnt=2; next 2 returns dropped; first delivered out_pc=0x80001000.
4. Redirect to 0x80000002 with 2 in flight -> no request; after stale returns drain, one entry: out_exception=1, out_exccode=5'h04, out_pc=0x80000002; no further requests until redirect.
5. fetch_pc 0xfffffffc accepted -> next fetch_pc 0x00000000 (wrap).
6. With PRE_IF_KSEG_MAP_EN, fetch 0xbfc00000 -> inst_sram_addr=0x1fc00000, cached=0; 0x80000000 -> 0x00000000, cached=1.
